axis_ttl_chk: RTL and testbench
===============================

Name: axis_ttl_chk

Overview:
Ingress-side TTL/hop-limit checker for the l3fwd action pipe. It is the counterpart of the egress TTL decrement stage.
- Inspects the first beat of each AXI-Stream packet.
- Packets whose IPv4 TTL or IPv6 hop limit is 0 or 1 are discarded whole, or redirected to the CPU port.
- Maintains saturating packet and expiry counters.
- Output is registered through a skid buffer. Payload is never modified.

Parameters:
DATA_WIDTH, 512, tdata width; minimum 256.
KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
ID_WIDTH, 8, tid width.
DEST_WIDTH, 4, tdest width.
USER_WIDTH, 16, tuser width.
PT_IPV4 / PT_VLV4 / PT_IPV6 / PT_VLV6, 4'h1 / 4'h2 / 4'h3 / 4'h4, packet-type codes carried in tuser.
PT_OFFSET, 8, LSB of the packet-type field in tuser.
PT_WIDTH, 4, packet-type field width.
REDIRECT, 0, 0 = drop expired packets; 1 = forward them with tdest = CPU_DEST.
CPU_DEST, 0, tdest value used for redirected packets.
CNT_WIDTH, 32, statistics counter width.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in (tready out)  per parameters  ingress stream.
m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  out (tready in)  per parameters  egress stream.
stat_pkt_count  out  CNT_WIDTH  packets seen (first beats accepted).
stat_exp_count  out  CNT_WIDTH  expired packets.
stat_exp_pulse  out  1  one-cycle pulse per expired packet.

Behaviour:
Reset:
- State = FIRST.
- m_axis_tvalid = 0; all m_axis data registers = 0.
- s_axis_tready = 0 in the first cycle after reset.
- Counters = 0; stat_exp_pulse = 0.

Byte ordering:
- Byte n of the frame sits at tdata[8n+7:8n].
- TTL byte index: IPV4 = 22, VLV4 = 26, IPV6 = 21, VLV6 = 25.

Expired:
- Requires pkt_type in {IPV4, VLV4, IPV6, VLV6} and tkeep[index] = 1 and TTL byte <= 1.
- Any other packet type, or the TTL byte absent (tkeep = 0), counts as not expired.

State machine (advances only on an accepted beat, tvalid && tready):
- FIRST:
  - Increment stat_pkt_count.
  - If expired: pulse stat_exp_pulse and increment stat_exp_count.
  - If expired and REDIRECT = 0: beat is not forwarded; go to DROP if !tlast, else stay in FIRST.
  - If expired and REDIRECT = 1: forward the beat with tdest = CPU_DEST and latch redir = 1; go to PASS if !tlast.
  - Otherwise: forward unchanged, latch redir = 0; go to PASS if !tlast.
- PASS:
  - Forward each beat; tdest = CPU_DEST if redir, else the input tdest.
  - On tlast, go to FIRST.
- DROP:
  - s_axis_tready = 1 unconditionally; beats are discarded.
  - On tlast, go to FIRST.

Handshake and latency:
- In FIRST and PASS, s_axis_tready = the registered internal ready from the 2-entry skid buffer.
- tready never depends combinationally on tdata or tvalid.
- One cycle latency from input accept to m_axis_tvalid.
- Full throughput when m_axis_tready = 1.
- m_axis data is held stable while tvalid && !tready.

Counters:
- Saturate at all-ones and never wrap.
- A single-beat packet (FIRST with tlast) counts exactly once.

Reset mid-packet:
- State returns to FIRST and the buffered beats are discarded.
- The next accepted beat is treated as a packet start.

Decomposition:
- Shared package l3fwd_pkg holds:
  - the PT_* codes;
  - TTL byte-index localparams;
  - the state encoding (FIRST = 0, PASS = 1, DROP = 2).
- Natural sub-module: axis_skid_reg (2-entry register slice with registered ready), reusable by the other action-pipe stages.

Test Plan:
1. IPV4 single-beat packet, byte22 = 0x40 -> output identical, 1-cycle latency; stat_pkt_count = 1, stat_exp_count = 0.
2. VLV4 three-beat packet, byte26 = 0x01, REDIRECT = 0 -> no output beats; s_axis_tready = 1 through beats 2-3; stat_exp_pulse one cycle; stat_exp_count = 1.
3. IPV6 two-beat packet, byte21 = 0x00, REDIRECT = 1, CPU_DEST = 4'hF, input tdest = 4'h3 -> both output beats carry tdest = 4'hF; data unchanged.
4. Back-to-back packets (expired VLV6 byte25 = 0x01, then IPV4 TTL = 0x02) with m_axis_tready toggling 1/0 every cycle -> only the second packet emerges; no lost or duplicated beat; data stable during stalls.
5. Non-IP pkt_type 4'h0 with byte22 = 0x00, plus an IPV4 packet with tkeep[22] = 0 -> both forwarded, not counted as expired.
6. Reset asserted mid-packet in PASS, then a fresh IPV4 packet with TTL = 0x01 -> m_axis_tvalid = 0 after reset; the fresh packet is dropped and the counters read 1/1.

Source files
------------

// File: rtl/l3fwd_pkg.sv
// Shared definitions for the l3fwd action pipe: packet-type codes, TTL byte
// positions within the first beat, and the TTL checker state encoding.
package l3fwd_pkg;

  localparam logic [3:0] L3_PT_IPV4 = 4'h1;
  localparam logic [3:0] L3_PT_VLV4 = 4'h2;
  localparam logic [3:0] L3_PT_IPV6 = 4'h3;
  localparam logic [3:0] L3_PT_VLV6 = 4'h4;

  // Byte offsets from frame start; VLAN variants shift by the 4-byte tag.
  localparam int TTL_IDX_IPV4 = 22;
  localparam int TTL_IDX_VLV4 = 26;
  localparam int TTL_IDX_IPV6 = 21;
  localparam int TTL_IDX_VLV6 = 25;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_PASS  = 2'd1,
    ST_DROP  = 2'd2
  } ttl_state_e;

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry AXI-Stream register slice. Upstream ready is a flop, so it never
// depends combinationally on downstream ready or on the payload.
module axis_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             ready_q;
  logic             in_fire;

  assign in_fire   = s_valid_i && ready_q;
  assign s_ready_o = ready_q;
  assign m_valid_o = out_valid_q;
  assign m_data_o  = out_data_q;

  // ready_q mirrors "skid empty", so a beat can never arrive while the skid is full.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (m_ready_i || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) out_data_d = s_data_i;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= !skid_valid_d;
    end
  end

endmodule

// File: rtl/axis_ttl_chk.sv
// Ingress TTL / hop-limit checker: packets whose first beat shows TTL <= 1 are
// dropped whole or steered to the CPU port; payload passes through unmodified.
module axis_ttl_chk
  import l3fwd_pkg::*;
#(
  parameter int                    DATA_WIDTH = 512,
  parameter int                    KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int                    ID_WIDTH   = 8,
  parameter int                    DEST_WIDTH = 4,
  parameter int                    USER_WIDTH = 16,
  parameter int                    PT_OFFSET  = 8,
  parameter int                    PT_WIDTH   = 4,
  parameter logic [PT_WIDTH-1:0]   PT_IPV4    = PT_WIDTH'(L3_PT_IPV4),
  parameter logic [PT_WIDTH-1:0]   PT_VLV4    = PT_WIDTH'(L3_PT_VLV4),
  parameter logic [PT_WIDTH-1:0]   PT_IPV6    = PT_WIDTH'(L3_PT_IPV6),
  parameter logic [PT_WIDTH-1:0]   PT_VLV6    = PT_WIDTH'(L3_PT_VLV6),
  parameter int                    REDIRECT   = 0,
  parameter logic [DEST_WIDTH-1:0] CPU_DEST   = '0,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [CNT_WIDTH-1:0]  stat_pkt_count,
  output logic [CNT_WIDTH-1:0]  stat_exp_count,
  output logic                  stat_exp_pulse
);

  localparam int  PW       = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam bit  REDIR_EN = (REDIRECT != 0);

  ttl_state_e            state_q, state_d;
  logic                  redir_q, redir_d;
  logic [PT_WIDTH-1:0]   pkt_type;
  logic                  expired;
  logic                  fwd;
  logic [DEST_WIDTH-1:0] dest_sel;
  logic                  accept;
  logic                  first_acc;
  logic                  skid_ready;
  logic [PW-1:0]         skid_in, skid_out;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, exp_cnt_q;
  logic                  pulse_q;

  function automatic logic ttl_low(input logic [DATA_WIDTH-1:0] d,
                                   input logic [KEEP_WIDTH-1:0] k,
                                   input int idx);
    return k[idx] && (d[8*idx +: 8] <= 8'd1);
  endfunction

  assign pkt_type = s_axis_tuser[PT_OFFSET +: PT_WIDTH];

  always_comb begin
    expired = 1'b0;
    if      (pkt_type == PT_IPV4) expired = ttl_low(s_axis_tdata, s_axis_tkeep, TTL_IDX_IPV4);
    else if (pkt_type == PT_VLV4) expired = ttl_low(s_axis_tdata, s_axis_tkeep, TTL_IDX_VLV4);
    else if (pkt_type == PT_IPV6) expired = ttl_low(s_axis_tdata, s_axis_tkeep, TTL_IDX_IPV6);
    else if (pkt_type == PT_VLV6) expired = ttl_low(s_axis_tdata, s_axis_tkeep, TTL_IDX_VLV6);
  end

  // DROP sinks beats regardless of the slice so a stalled egress cannot block discard.
  assign s_axis_tready = (state_q == ST_DROP) ? 1'b1 : skid_ready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign first_acc     = accept && (state_q == ST_FIRST);

  always_comb begin
    state_d  = state_q;
    redir_d  = redir_q;
    fwd      = 1'b0;
    dest_sel = s_axis_tdest;
    case (state_q)
      ST_FIRST: begin
        fwd = !(expired && !REDIR_EN);
        if (expired && REDIR_EN) dest_sel = CPU_DEST;
        if (accept) begin
          redir_d = expired && REDIR_EN;
          if (!s_axis_tlast) state_d = fwd ? ST_PASS : ST_DROP;
        end
      end
      ST_PASS: begin
        fwd = 1'b1;
        if (redir_q) dest_sel = CPU_DEST;
        if (accept && s_axis_tlast) state_d = ST_FIRST;
      end
      ST_DROP: begin
        if (accept && s_axis_tlast) state_d = ST_FIRST;
      end
      default: state_d = ST_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FIRST;
      redir_q   <= 1'b0;
      pkt_cnt_q <= '0;
      exp_cnt_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      redir_q <= redir_d;
      pulse_q <= first_acc && expired;
      if (first_acc && (pkt_cnt_q != '1)) pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
      if (first_acc && expired && (exp_cnt_q != '1)) exp_cnt_q <= exp_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign skid_in = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tid, dest_sel, s_axis_tuser};

  axis_skid_reg #(
    .WIDTH(PW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .s_valid_i(s_axis_tvalid && fwd),
    .s_ready_o(skid_ready),
    .s_data_i (skid_in),
    .m_valid_o(m_axis_tvalid),
    .m_ready_i(m_axis_tready),
    .m_data_o (skid_out)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = skid_out;

  assign stat_pkt_count = pkt_cnt_q;
  assign stat_exp_count = exp_cnt_q;
  assign stat_exp_pulse = pulse_q;

endmodule

// File: tb/tb_axis_ttl_chk.sv
// Directed bench for axis_ttl_chk: instance A drops expired packets, instance B
// redirects them to CPU_DEST 4'hF; egress beats are checked against queues.
module tb_axis_ttl_chk;

  localparam int DW = 256;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [7:0]    id;
    logic [3:0]    dest;
    logic [15:0]   user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic [7:0]    s_tid = '0;
  logic [3:0]    s_tdest = '0;
  logic [15:0]   s_tuser = '0;
  logic          s_tvalid_a = 1'b0, s_tvalid_b = 1'b0;
  logic          s_tready_a, s_tready_b;
  logic          m_tready = 1'b1;
  logic          toggle_en = 1'b0;

  logic [DW-1:0] m_tdata_a, m_tdata_b;
  logic [KW-1:0] m_tkeep_a, m_tkeep_b;
  logic          m_tvalid_a, m_tvalid_b, m_tlast_a, m_tlast_b;
  logic [7:0]    m_tid_a, m_tid_b;
  logic [3:0]    m_tdest_a, m_tdest_b;
  logic [15:0]   m_tuser_a, m_tuser_b;
  logic [31:0]   pkt_cnt_a, exp_cnt_a, pkt_cnt_b, exp_cnt_b;
  logic          pulse_a, pulse_b;

  beat_t out_a, out_b;
  beat_t q_a[$];
  beat_t q_b[$];
  int    checks = 0;
  int    errors = 0;
  int    pulses_a = 0;
  int    pulses_b = 0;

  always #5 clk = ~clk;

  axis_ttl_chk #(.DATA_WIDTH(DW), .REDIRECT(0)) dut_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid_a),
    .s_axis_tready(s_tready_a), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata_a), .m_axis_tkeep(m_tkeep_a), .m_axis_tvalid(m_tvalid_a),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast_a), .m_axis_tid(m_tid_a),
    .m_axis_tdest(m_tdest_a), .m_axis_tuser(m_tuser_a),
    .stat_pkt_count(pkt_cnt_a), .stat_exp_count(exp_cnt_a), .stat_exp_pulse(pulse_a)
  );

  axis_ttl_chk #(.DATA_WIDTH(DW), .REDIRECT(1), .CPU_DEST(4'hF)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid_b),
    .s_axis_tready(s_tready_b), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata_b), .m_axis_tkeep(m_tkeep_b), .m_axis_tvalid(m_tvalid_b),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast_b), .m_axis_tid(m_tid_b),
    .m_axis_tdest(m_tdest_b), .m_axis_tuser(m_tuser_b),
    .stat_pkt_count(pkt_cnt_b), .stat_exp_count(exp_cnt_b), .stat_exp_pulse(pulse_b)
  );

  assign out_a = {m_tdata_a, m_tkeep_a, m_tlast_a, m_tid_a, m_tdest_a, m_tuser_a};
  assign out_b = {m_tdata_b, m_tkeep_b, m_tlast_b, m_tid_b, m_tdest_b, m_tuser_b};

  always @(posedge clk) begin
    #1;
    if (toggle_en) m_tready = ~m_tready;
  end

  // Every valid cycle is compared with the queue head, so stalls also prove hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid_a) begin
        checks++;
        assert (q_a.size() != 0) else begin
          errors++; $error("FAIL unexpected_beat_a observed=%h expected=none", out_a);
        end
        if (q_a.size() != 0) begin
          checks++;
          assert (out_a === q_a[0]) else begin
            errors++; $error("FAIL beat_a observed=%h expected=%h", out_a, q_a[0]);
          end
          if (m_tready) void'(q_a.pop_front());
        end
      end
      if (m_tvalid_b) begin
        checks++;
        assert (q_b.size() != 0) else begin
          errors++; $error("FAIL unexpected_beat_b observed=%h expected=none", out_b);
        end
        if (q_b.size() != 0) begin
          checks++;
          assert (out_b === q_b[0]) else begin
            errors++; $error("FAIL beat_b observed=%h expected=%h", out_b, q_b[0]);
          end
          if (m_tready) void'(q_b.pop_front());
        end
      end
      if (pulse_a) pulses_a++;
      if (pulse_b) pulses_b++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [3:0] pt, input int idx, input logic [7:0] ttl,
                               input logic last, input logic [3:0] dest);
    beat_t b;
    for (int i = 0; i < DW / 32; i++) b.data[32*i +: 32] = $urandom;
    b.keep      = '1;
    b.last      = last;
    b.id        = 8'($urandom);
    b.dest      = dest;
    b.user      = 16'($urandom);
    b.user[11:8] = pt;
    if (idx >= 0) b.data[8*idx +: 8] = ttl;
    return b;
  endfunction

  // Pushes the expected egress beat (if any) and then drives one beat to the chosen DUT.
  task automatic send(input bit sel, input beat_t b, input bit fwd, input logic [3:0] dest_out,
                      output int waits);
    beat_t e;
    bit    rdy;
    e = b;
    e.dest = dest_out;
    if (fwd) begin
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end
    s_tdata = b.data; s_tkeep = b.keep; s_tlast = b.last;
    s_tid = b.id; s_tdest = b.dest; s_tuser = b.user;
    if (sel) s_tvalid_b = 1'b1;
    else     s_tvalid_a = 1'b1;
    waits = 0;
    rdy = 1'b0;
    while (!rdy && waits < 200) begin
      rdy = sel ? s_tready_b : s_tready_a;
      @(posedge clk);
      #1;
      if (!rdy) waits++;
    end
    s_tvalid_a = 1'b0;
    s_tvalid_b = 1'b0;
    chk("accept_timeout", 64'(rdy), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain", 64'(q_a.size() + q_b.size()), 64'd0);
  endtask

  initial begin
    beat_t b;
    int    w;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_tready", 64'(s_tready_a), 64'd0);
    chk("rst_tvalid", 64'(m_tvalid_a), 64'd0);
    chk("rst_tdata", 64'(m_tdata_a[63:0]), 64'd0);
    chk("rst_cnt", {pkt_cnt_a, exp_cnt_a}, 64'd0);
    chk("rst_pulse", 64'(pulse_a), 64'd0);
    @(posedge clk);
    #1;
    chk("tready_up", 64'(s_tready_a), 64'd1);

    // 1: live IPv4 single beat, one-cycle latency
    b = mk(4'h1, 22, 8'h40, 1'b1, 4'h5);
    send(1'b0, b, 1'b1, 4'h5, w);
    chk("t1_latency", 64'(m_tvalid_a), 64'd1);
    drain();
    chk("t1_cnt", {pkt_cnt_a, exp_cnt_a}, {32'd1, 32'd0});

    // 2: expired VLV4 three-beat packet dropped
    b = mk(4'h2, 26, 8'h01, 1'b0, 4'h2);
    send(1'b0, b, 1'b0, 4'h2, w);
    b = mk(4'h0, -1, 8'h00, 1'b0, 4'h2);
    send(1'b0, b, 1'b0, 4'h2, w);
    chk("t2_drop_ready_b2", 64'(w), 64'd0);
    b = mk(4'h0, -1, 8'h00, 1'b1, 4'h2);
    send(1'b0, b, 1'b0, 4'h2, w);
    chk("t2_drop_ready_b3", 64'(w), 64'd0);
    drain();
    chk("t2_cnt", {pkt_cnt_a, exp_cnt_a}, {32'd2, 32'd1});
    chk("t2_pulses", 64'(pulses_a), 64'd1);

    // 3: expired IPv6 redirected to CPU port on instance B
    b = mk(4'h3, 21, 8'h00, 1'b0, 4'h3);
    send(1'b1, b, 1'b1, 4'hF, w);
    b = mk(4'h0, -1, 8'h00, 1'b1, 4'h3);
    send(1'b1, b, 1'b1, 4'hF, w);
    drain();
    chk("t3_cnt", {pkt_cnt_b, exp_cnt_b}, {32'd1, 32'd1});
    chk("t3_pulses", 64'(pulses_b), 64'd1);

    // 4: back-to-back expired VLV6 then live IPv4 with toggling egress ready
    toggle_en = 1'b1;
    b = mk(4'h4, 25, 8'h01, 1'b0, 4'h1);
    send(1'b0, b, 1'b0, 4'h1, w);
    for (int i = 0; i < 2; i++) begin
      b = mk(4'h0, -1, 8'h00, i == 1, 4'h1);
      send(1'b0, b, 1'b0, 4'h1, w);
    end
    b = mk(4'h1, 22, 8'h02, 1'b0, 4'h6);
    send(1'b0, b, 1'b1, 4'h6, w);
    for (int i = 0; i < 3; i++) begin
      b = mk(4'h4, 25, 8'h00, i == 2, 4'h6);
      send(1'b0, b, 1'b1, 4'h6, w);
    end
    drain();
    toggle_en = 1'b0;
    #2;
    m_tready = 1'b1;
    chk("t4_cnt", {pkt_cnt_a, exp_cnt_a}, {32'd4, 32'd2});
    chk("t4_pulses", 64'(pulses_a), 64'd2);

    // 5: non-IP type and IPv4 with the TTL byte masked off both pass
    b = mk(4'h0, 22, 8'h00, 1'b1, 4'h7);
    send(1'b0, b, 1'b1, 4'h7, w);
    b = mk(4'h1, 22, 8'h00, 1'b1, 4'h8);
    b.keep[22] = 1'b0;
    send(1'b0, b, 1'b1, 4'h8, w);
    drain();
    chk("t5_cnt", {pkt_cnt_a, exp_cnt_a}, {32'd6, 32'd2});

    // 6: reset in PASS with beats buffered, then an expired single-beat packet
    m_tready = 1'b0;
    b = mk(4'h1, 22, 8'h40, 1'b0, 4'h9);
    send(1'b0, b, 1'b1, 4'h9, w);
    b = mk(4'h0, -1, 8'h00, 1'b0, 4'h9);
    send(1'b0, b, 1'b1, 4'h9, w);
    rst = 1'b1;
    q_a.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pulses_a = 0;
    chk("t6_tvalid", 64'(m_tvalid_a), 64'd0);
    chk("t6_cnt_rst", {pkt_cnt_a, exp_cnt_a}, 64'd0);
    m_tready = 1'b1;
    b = mk(4'h1, 22, 8'h01, 1'b1, 4'h9);
    send(1'b0, b, 1'b0, 4'h9, w);
    drain();
    chk("t6_cnt", {pkt_cnt_a, exp_cnt_a}, {32'd1, 32'd1});
    chk("t6_pulses", 64'(pulses_a), 64'd1);
    chk("t6_idle", 64'(m_tvalid_a), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
